crc_stream_engine: RTL
======================

# crc_stream_engine

Parametrised streaming CRC generator/checker, the successor to the fixed 16-bit CRC16_D16 engine. It folds one DATA_W-bit beat per clock into a CRC_W-bit remainder with any polynomial, init value, reflection and final XOR. A valid/ready handshake with frame delimiting (sync/in_last) returns a registered result plus a residue-check flag. It sits on the link datapath between framer and MAC, used for both TX CRC insertion and RX CRC checking.

## Interface
- DATA_W, 16: beat width in bits; 8, 16, 32 or 64.
- CRC_W, 16: CRC width; 8..32.
- POLY, 16'h1021: generator polynomial, normal form, implicit top bit.
- INIT, 16'hFFFF: register value at frame start.
- XOR_OUT, 16'h0000: XOR applied to the final result.
- REFIN, 0: 1 = each input byte is bit-reversed before folding.
- REFOUT, 0: 1 = the final remainder is bit-reversed over CRC_W before XOR_OUT.
- RESIDUE, 16'h0000: raw register value (pre-REFOUT, pre-XOR_OUT) expected after message plus appended CRC.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- sync  in  1  qualified by in_valid: this beat starts a new frame; fold from INIT.
- in_valid  in  1  Data/sync/in_last valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- Data  in  DATA_W  beat, MSB-first (byte 0 in [DATA_W-1:DATA_W-8]).
- in_last  in  1  qualified by in_valid: final beat of frame.
- newcrc  out  CRC_W  final CRC of the last completed frame.
- out_valid  out  1  newcrc/crc_ok valid; held until out_ready.
- out_ready  in  1  consumer accepts result.
- crc_ok  out  1  raw register == RESIDUE at frame end.
- err  out  1  one-cycle pulse on protocol error.

## Operation
- State: IDLE (no open frame), BUSY (frame open). Register crc_q[CRC_W-1:0]. Result registers newcrc, crc_ok, out_valid.
- in_ready = !out_valid || out_ready (combinational; one-deep result buffer, no bubble on continuous frames).
- Next-state function f(s, d): bit-serial LFSR unrolled over DATA_W bits, MSB first. After REFIN byte reversal each step is: fb = s[CRC_W-1] ^ bit; s = {s[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0). Purely combinational, one beat per cycle.
- Start value: INIT if (sync || state==IDLE), else crc_q.
- Accepted beat, not last: crc_q <= f(start, Data); state -> BUSY.
- Accepted beat with in_last: raw = f(start, Data). Then newcrc <= (REFOUT ? rev(raw) : raw) ^ XOR_OUT; crc_ok <= (raw == RESIDUE); out_valid <= 1; crc_q <= INIT; state -> IDLE. sync+in_last on one beat is a legal single-beat frame.
- out_valid clears on out_valid && out_ready unless a new last beat is accepted the same cycle, in which case it stays 1 with the new result.
- err pulses when sync is accepted in BUSY: the open frame is discarded and the new one starts from INIT. It also pulses when a beat without sync is accepted in IDLE: that beat is folded from INIT (implicit start).
- Reset (asserted low): crc_q = INIT, state = IDLE, newcrc = 0, crc_ok = 0, out_valid = 0, err = 0. Reset mid-frame discards the frame; no result is emitted.

## Timing
- Latency: result visible on newcrc/out_valid the cycle after the in_last beat handshake.
- Throughput: one beat per clock while out_ready high, including back-to-back frames.
- Stall: out_valid && !out_ready drops in_ready. Data, sync and in_last are ignored until the handshake; crc_q and newcrc are held.
- err is registered, high one cycle after the offending handshake.
- in_valid without in_ready: no state change.

## Test plan
- CRC-16/CCITT-FALSE defaults, DATA_W=8: "123456789" (0x31..0x39) with sync on first beat, in_last on 0x39, out_ready=1 -> newcrc=0x29B1 one cycle after last beat, out_valid for one cycle, err=0.
- Same config, INIT=0 (XMODEM): same bytes -> newcrc=0x31C3. Then check mode: "123456789",0x29,0xB1 with INIT=0xFFFF -> crc_ok=1. Flip Data bit 0 of byte '5' -> crc_ok=0.
- CRC-32 (POLY=32'h04C11DB7, INIT/XOR_OUT=32'hFFFFFFFF, REFIN=REFOUT=1, DATA_W=8): "123456789" -> newcrc=32'hCBF43926. DATA_W=32, words 0x31323334, 0x35363738 -> matches the byte-wise model for "12345678".
- Backpressure: two back-to-back 4-beat frames, out_ready low 5 cycles after first result -> in_ready low, first newcrc held stable, second frame resumes without corruption and yields its model CRC.
- Protocol errors: sync mid-frame at beat 3 -> err pulse, result equals CRC of new frame only. Non-sync beat in IDLE -> err pulse, CRC computed from INIT.
- Reset low mid-frame (async, between edges) -> out_valid=0, newcrc=0 immediately. Next frame "123456789" -> 0x29B1.

Source files
------------

// File: rtl/crc_stream_engine_if.sv
// Beat-in / result-out handshake bundle for the streaming CRC engine.
interface crc_stream_engine_if #(
    parameter int DATA_W = 16,
    parameter int CRC_W  = 16
);
    logic              sync;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] Data;
    logic              in_last;
    logic [CRC_W-1:0]  newcrc;
    logic              out_valid;
    logic              out_ready;
    logic              crc_ok;
    logic              err;

    modport master (
        output sync, in_valid, Data, in_last, out_ready,
        input  in_ready, newcrc, out_valid, crc_ok, err
    );

    modport slave (
        input  sync, in_valid, Data, in_last, out_ready,
        output in_ready, newcrc, out_valid, crc_ok, err
    );
endinterface

// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker folding one DATA_W beat per clock; result registered the cycle after the last beat.
// A held result (out_valid && !out_ready) drops in_ready; beats are only consumed on in_valid && in_ready.
module crc_stream_engine #(
    parameter int               DATA_W  = 16,
    parameter int               CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = 16'h1021,
    parameter logic [CRC_W-1:0] INIT    = 16'hFFFF,
    parameter logic [CRC_W-1:0] XOR_OUT = 16'h0000,
    parameter bit               REFIN   = 1'b0,
    parameter bit               REFOUT  = 1'b0,
    parameter logic [CRC_W-1:0] RESIDUE = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    crc_stream_engine_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CRC_W-1:0] newcrc_q, newcrc_d;
    logic             ok_q, ok_d;
    logic             ov_q, ov_d;
    logic             err_q, err_d;
    logic             in_ready;
    logic             accept;
    logic [CRC_W-1:0] start;
    logic [CRC_W-1:0] raw;

    // Bytes are reflected individually, then the whole beat is shifted in MSB first.
    function automatic logic [CRC_W-1:0] fold(input logic [CRC_W-1:0] s, input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0]  c;
        logic [DATA_W-1:0] x;
        logic              fb;
        for (int b = 0; b < DATA_W / 8; b++) begin
            for (int k = 0; k < 8; k++) begin
                x[b*8+k] = REFIN ? d[b*8+7-k] : d[b*8+k];
            end
        end
        c = s;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ x[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    function automatic logic [CRC_W-1:0] rev(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) begin
            r[i] = v[CRC_W-1-i];
        end
        return r;
    endfunction

    assign in_ready = !ov_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign start    = (bus.sync || state_q == IDLE) ? INIT : crc_q;
    assign raw      = fold(start, bus.Data);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            crc_q    <= INIT;
            newcrc_q <= '0;
            ok_q     <= 1'b0;
            ov_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            crc_q    <= crc_d;
            newcrc_q <= newcrc_d;
            ok_q     <= ok_d;
            ov_q     <= ov_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = bus.in_last ? IDLE : BUSY;
        end
    end

    always_comb begin
        crc_d    = crc_q;
        newcrc_d = newcrc_q;
        ok_d     = ok_q;
        ov_d     = ov_q;
        err_d    = 1'b0;
        if (accept) begin
            // sync inside an open frame restarts; a beat without sync while idle is an implicit start.
            err_d = (bus.sync && state_q == BUSY) || (!bus.sync && state_q == IDLE);
            if (bus.in_last) begin
                crc_d    = INIT;
                newcrc_d = (REFOUT ? rev(raw) : raw) ^ XOR_OUT;
                ok_d     = (raw == RESIDUE);
            end else begin
                crc_d    = raw;
            end
        end
        if (accept && bus.in_last) begin
            ov_d = 1'b1;
        end else if (ov_q && bus.out_ready) begin
            ov_d = 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.newcrc    = newcrc_q;
    assign bus.crc_ok    = ok_q;
    assign bus.out_valid = ov_q;
    assign bus.err       = err_q;
endmodule
